// File: rtl/pc_sequencer.sv
// Next-PC controller: drives pcin for the external pc register, runs the
// fetch handshake with instruction memory, and keeps a small return-address
// stack for call/ret. Sticky flags record stack misuse until reset.
module pc_sequencer #(
    parameter int                 WIDTH       = 8,
    parameter int                 STACK_DEPTH = 4,
    parameter logic [WIDTH-1:0]   RESET_VEC   = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] pcout,
    output logic [WIDTH-1:0] pcin,
    output logic             fetch_req,
    input  logic             fetch_ack,
    input  logic             stall,
    input  logic             halt,
    input  logic             resume,
    input  logic             br_taken,
    input  logic [WIDTH-1:0] br_offset,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             call,
    input  logic             ret,
    output logic             stack_overflow,
    output logic             stack_underflow,
    output logic [1:0]       seq_state
);

    // Stack pointer counts occupied entries, so it needs one bit more than
    // the entry index to represent "full".
    localparam int AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
    localparam int PW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FETCH  = 2'b01,
        HALTED = 2'b10
    } state_t;

    state_t           state;
    state_t           next_state;
    logic [PW-1:0]    sp;
    logic [WIDTH-1:0] stack [STACK_DEPTH];

    logic             stack_empty;
    logic             stack_full;
    logic [AW-1:0]    top_idx;
    logic [WIDTH-1:0] top_entry;
    logic [WIDTH-1:0] pc_inc;
    logic             do_push;
    logic             do_pop;
    logic             set_ovf;
    logic             set_unf;

    assign stack_empty = (sp == '0);
    assign stack_full  = (sp == PW'(STACK_DEPTH));
    assign top_idx     = AW'(sp - PW'(1));
    assign top_entry   = stack[top_idx];
    assign pc_inc      = pcout + WIDTH'(1);
    assign seq_state   = state;

    // Next-state, next-PC and stack control; an advance happens only on an
    // accepted fetch, and the redirect sources are resolved by priority.
    always_comb begin
        next_state = state;
        pcin       = pcout;
        fetch_req  = 1'b0;
        do_push    = 1'b0;
        do_pop     = 1'b0;
        set_ovf    = 1'b0;
        set_unf    = 1'b0;
        case (state)
            IDLE: begin
                pcin       = RESET_VEC;
                next_state = FETCH;
            end
            FETCH: begin
                if (!stall) begin
                    fetch_req = 1'b1;
                    if (fetch_ack) begin
                        // Offset and PC share a width, so the modular add
                        // already behaves as a sign-extended relative branch.
                        if (ret) begin
                            if (!stack_empty) begin
                                pcin   = top_entry;
                                do_pop = 1'b1;
                            end else begin
                                pcin    = pc_inc;
                                set_unf = 1'b1;
                            end
                        end else if (call) begin
                            pcin = jump_target;
                            if (!stack_full) begin
                                do_push = 1'b1;
                            end else begin
                                set_ovf = 1'b1;
                            end
                        end else if (jump) begin
                            pcin = jump_target;
                        end else if (br_taken) begin
                            pcin = pc_inc + br_offset;
                        end else begin
                            pcin = pc_inc;
                        end
                        if (halt) begin
                            next_state = HALTED;
                        end
                    end
                end
            end
            HALTED: begin
                if (resume && !halt) begin
                    next_state = FETCH;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    // State register, stack pointer and sticky error flags.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            sp              <= '0;
            stack_overflow  <= 1'b0;
            stack_underflow <= 1'b0;
        end else begin
            state <= next_state;
            if (do_push) begin
                sp <= sp + PW'(1);
            end else if (do_pop) begin
                sp <= sp - PW'(1);
            end
            if (set_ovf) begin
                stack_overflow <= 1'b1;
            end
            if (set_unf) begin
                stack_underflow <= 1'b1;
            end
        end
    end

    // Return-address storage; contents need no reset because the pointer
    // alone decides which entries are valid.
    always_ff @(posedge clock) begin
        if (do_push) begin
            stack[sp[AW-1:0]] <= pc_inc;
        end
    end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Next-PC controller for the 8-bit `pc` register. It drives the register's `pcin` each cycle and runs a small fetch state machine that handshakes with instruction memory. It selects increment, relative branch, absolute jump, or call/return from an internal return-address stack, and holds the PC on stall, fetch wait or halt. It sits between decode/branch logic and the `pc` register; that register's `pcout` feeds back into this block.

Parameters:
WIDTH, 8, PC and address width
STACK_DEPTH, 4, return-address stack entries (power of two, 2..16)
RESET_VEC, 8'h00, PC value driven on pcin in IDLE

Ports:
clock  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
pcout  input  WIDTH  current PC from the pc register
pcin  output  WIDTH  next PC to the pc register (combinational from state, stack and inputs)
fetch_req  output  1  instruction fetch request at address pcout
fetch_ack  input  1  instruction memory has returned the word for pcout this cycle
stall  input  1  pipeline stall; hold PC, suppress fetch_req
halt  input  1  halt request from decode
resume  input  1  leave HALTED
br_taken  input  1  relative branch taken
br_offset  input  WIDTH  two's-complement branch offset
jump  input  1  absolute jump
jump_target  input  WIDTH  jump or call target
call  input  1  push return address, go to jump_target
ret  input  1  pop return address
stack_overflow  output  1  sticky: a call occurred with the stack full
stack_underflow  output  1  sticky: a ret occurred with the stack empty
seq_state  output  2  00 IDLE, 01 FETCH, 10 HALTED

Behaviour:
- Reset (asynchronous): state=IDLE, stack pointer=0, both sticky flags=0, fetch_req=0, pcin=RESET_VEC. Stack contents are don't-care.
- IDLE: pcin=RESET_VEC, fetch_req=0. Unconditionally moves to FETCH on the next clock.
- FETCH with stall=1: pcin=pcout, fetch_req=0. fetch_ack, halt and all redirect inputs are ignored. Stay in FETCH.
- FETCH with stall=0: fetch_req=1.
  - fetch_ack=0: pcin=pcout (hold). Redirect inputs and halt are ignored.
  - fetch_ack=1: the PC advances this cycle; pcout updates on the next edge (one-cycle latency through `pc`).
- Advance priority (highest first), all arithmetic modulo 2^WIDTH:
  1. ret, stack not empty: pcin=top entry; pointer decrements.
  2. ret, stack empty: pcin=pcout+1; stack_underflow set.
  3. call, stack not full: push pcout+1; pcin=jump_target.
  4. call, stack full: no push; stack_overflow set; pcin=jump_target.
  5. jump: pcin=jump_target.
  6. br_taken: pcin=pcout+1+br_offset, offset sign-extended.
  7. otherwise: pcin=pcout+1.
- Simultaneous ret and call: ret wins and the call is ignored (no push, no flag).
- Wrap-around: pcout=8'hFF with increment gives 8'h00.
- halt=1 together with an accepted fetch (fetch_ack=1, stall=0): the advance completes normally and the next state is HALTED.
- HALTED: pcin=pcout, fetch_req=0, all redirect inputs ignored.
  - resume=1 and halt=0: next state FETCH.
  - resume=1 and halt=1 in the same cycle: stay HALTED.
- Stack and sticky flags persist across HALTED and stall. The flags clear only on reset.
- Reset asserted mid-operation: immediate return to IDLE; any in-flight push or pop is discarded.

Test Plan:
- Reset, then fetch_ack=1 every cycle -> seq_state 00 then 01; pcout sequence 00,01,02,03; fetch_req=1 from the FETCH cycle onward.
- pcout=8'h10, br_taken=1, br_offset=8'hFC, ack=1 -> pcout=8'h0D next cycle. pcout=8'hFF with increment -> 8'h00.
- call at pcout=8'h20, target=8'h40; then ret at 8'h41 -> pcout=8'h40, then 8'h21; stack pointer back to 0; no flags set.
- Five nested calls with STACK_DEPTH=4 -> 5th jumps to its target, stack_overflow=1, and four rets return correctly. A 5th ret gives stack_underflow=1 and pcin=pcout+1.
- stall=1 or fetch_ack=0 held for 3 cycles with jump=1 asserted -> pcout unchanged and fetch_req=0 during stall. After release, a jump with ack moves pcout to the target.
- halt with ack at pcout=8'h30 -> pcout=8'h31 then held, seq_state=10. resume together with halt -> stays 10. resume alone -> FETCH, increment resumes. Reset pulse mid-sequence -> IDLE, both flags cleared.
